// File: rtl/branch_predict_unit.sv
// Direct-mapped branch predictor: tagged entries with saturating counters, bimodal or gshare indexing,
// combinational lookup, single-cycle update, saturating resolve/mispredict statistics.
module branch_predict_unit #(
  parameter int ENTRIES = 16,
  parameter int CNT_W   = 2,
  parameter int HIST_W  = 4,
  parameter int MODE    = 0
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic [31:0]                lookup_pc,
  output logic                       pred_taken,
  output logic [31:0]                pred_target,
  output logic                       pred_hit,
  output logic [$clog2(ENTRIES)-1:0] pred_idx,
  input  logic                       upd_en,
  input  logic [31:0]                upd_pc,
  input  logic [$clog2(ENTRIES)-1:0] upd_idx,
  input  logic                       upd_taken,
  input  logic [31:0]                upd_target,
  input  logic                       upd_pred_taken,
  input  logic                       stat_clr,
  output logic [31:0]                br_count,
  output logic [31:0]                mispred_count
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 30 - IDX_W;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_WEAK = CNT_W'(1) << (CNT_W - 1);

  logic             valid_q  [ENTRIES];
  logic             valid_d  [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [TAG_W-1:0] tag_d    [ENTRIES];
  logic [29:0]      target_q [ENTRIES];
  logic [29:0]      target_d [ENTRIES];
  logic [CNT_W-1:0] cnt_q    [ENTRIES];
  logic [CNT_W-1:0] cnt_d    [ENTRIES];
  logic [HIST_W-1:0] ghr_q, ghr_d;
  logic [31:0]      br_count_q, br_count_d;
  logic [31:0]      mispred_count_q, mispred_count_d;

  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] upd_tag;
  logic             upd_hit;
  logic             mispred;
  logic [5:0]       unused_bits;

  assign unused_bits = {lookup_pc[1:0], upd_pc[1:0], upd_target[1:0]};

  // History is zero-extended into the low index bits in gshare mode.
  always_comb begin
    lk_idx = lookup_pc[IDX_W+1:2];
    if (MODE == 1) lk_idx = lk_idx ^ IDX_W'(ghr_q);
  end

  assign pred_idx    = lk_idx;
  assign pred_hit    = valid_q[lk_idx] && (tag_q[lk_idx] == lookup_pc[31:IDX_W+2]);
  assign pred_taken  = pred_hit && cnt_q[lk_idx][CNT_W-1];
  assign pred_target = pred_hit ? {target_q[lk_idx], 2'b00} : lookup_pc + 32'd4;

  assign upd_tag = upd_pc[31:IDX_W+2];
  assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
  // A correctly-predicted taken branch still counts as a miss if it went somewhere else.
  assign mispred = (upd_pred_taken != upd_taken) ||
                   (upd_taken && upd_pred_taken && (target_q[upd_idx] != upd_target[31:2]));

  always_comb begin
    valid_d         = valid_q;
    tag_d           = tag_q;
    target_d        = target_q;
    cnt_d           = cnt_q;
    ghr_d           = ghr_q;
    br_count_d      = br_count_q;
    mispred_count_d = mispred_count_q;
    if (upd_en) begin
      ghr_d = HIST_W'({ghr_q, upd_taken});
      if (upd_hit) begin
        if (upd_taken) begin
          if (cnt_q[upd_idx] != CNT_MAX) cnt_d[upd_idx] = cnt_q[upd_idx] + CNT_W'(1);
          target_d[upd_idx] = upd_target[31:2];
        end else if (cnt_q[upd_idx] != '0) begin
          cnt_d[upd_idx] = cnt_q[upd_idx] - CNT_W'(1);
        end
      end else if (upd_taken) begin
        valid_d[upd_idx]  = 1'b1;
        tag_d[upd_idx]    = upd_tag;
        target_d[upd_idx] = upd_target[31:2];
        cnt_d[upd_idx]    = CNT_WEAK;
      end
      if (br_count_q != '1) br_count_d = br_count_q + 32'd1;
      if (mispred && (mispred_count_q != '1)) mispred_count_d = mispred_count_q + 32'd1;
    end
    if (stat_clr) begin
      br_count_d      = '0;
      mispred_count_d = '0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        cnt_q[i]   <= '0;
      end
      ghr_q           <= '0;
      br_count_q      <= '0;
      mispred_count_q <= '0;
    end else begin
      valid_q         <= valid_d;
      cnt_q           <= cnt_d;
      ghr_q           <= ghr_d;
      br_count_q      <= br_count_d;
      mispred_count_q <= mispred_count_d;
    end
  end

  // Tag and target are qualified by valid, so they carry no reset.
  always_ff @(posedge CLK) begin
    tag_q    <= tag_d;
    target_q <= target_d;
  end

  assign br_count      = br_count_q;
  assign mispred_count = mispred_count_q;

endmodule

// File: doc/branch_predict_unit.md
BRANCH_PREDICT_UNIT -- requirements
Module: branch_predict_unit

Interface
REQ-001 The block SHALL have the following parameters, one per line as name, default, meaning:
- ENTRIES, 16, number of table entries; power of two, 2..1024.
- CNT_W, 2, saturating-counter width, 1..4.
- HIST_W, 4, global-history width, 1..log2(ENTRIES).
- MODE, 0, index mode: 0 = bimodal, 1 = gshare.
REQ-002 The block SHALL derive IDX_W = log2(ENTRIES) and TAG_W = 30 - IDX_W.
REQ-003 The block SHALL have the following ports, one per line as name, direction, width, meaning:
- CLK, in, 1, single clock; all state changes on its rising edge.
- RST, in, 1, reset; asynchronous, active-high.
- lookup_pc, in, 32, PC of the instruction being fetched.
- pred_taken, out, 1, prediction: taken.
- pred_target, out, 32, predicted target; valid when pred_taken = 1.
- pred_hit, out, 1, tag match on a valid entry.
- pred_idx, out, IDX_W, table index used; travels down the pipe with the branch.
- upd_en, in, 1, branch resolved this cycle.
- upd_pc, in, 32, PC of the resolved branch.
- upd_idx, in, IDX_W, pred_idx carried with the resolved branch.
- upd_taken, in, 1, actual outcome.
- upd_target, in, 32, actual taken target.
- upd_pred_taken, in, 1, prediction that was made for this branch.
- stat_clr, in, 1, synchronous clear of the statistics counters.
- br_count, out, 32, resolved branches since reset or clear.
- mispred_count, out, 32, mispredictions since reset or clear.

Function
REQ-004 Lookup SHALL be combinational. MODE 0: index = lookup_pc[IDX_W+1:2]. MODE 1: index = lookup_pc[IDX_W+1:2] XOR ({(IDX_W-HIST_W){0}}, ghr).
REQ-005 pred_idx SHALL equal the index computed in REQ-004.
REQ-006 pred_hit SHALL be 1 if and only if valid[idx] = 1 and tag[idx] = lookup_pc[31:IDX_W+2].
REQ-007 pred_taken SHALL equal pred_hit AND cnt[idx][CNT_W-1].
REQ-008 pred_target SHALL equal target[idx] when pred_hit = 1, and lookup_pc + 4 otherwise.
REQ-009 Each entry SHALL hold: valid (1 bit), tag (TAG_W bits), target (30 bits, word address), cnt (CNT_W bits).
REQ-010 The update SHALL act at the rising edge with upd_en = 1 and SHALL use upd_idx, not a recomputed index.
REQ-011 Update on a tag hit (valid and tag = upd_pc[31:IDX_W+2]):
- cnt increments if upd_taken = 1, saturating at all-ones.
- cnt decrements if upd_taken = 0, saturating at 0.
- target is written with upd_target[31:2] when upd_taken = 1.
REQ-012 Update on a tag miss with upd_taken = 1 SHALL allocate the entry: valid = 1, tag = upd_pc tag, target = upd_target[31:2], cnt = 1 << (CNT_W-1) (weakly taken). The previous occupant is replaced.
REQ-013 Update on a tag miss with upd_taken = 0 SHALL leave the entry unchanged.
REQ-014 ghr (HIST_W bits) SHALL shift left with upd_taken inserted at bit 0 on every upd_en, in both modes. It affects indexing only in MODE 1.
REQ-015 A lookup and an update to the same index in the same cycle: the lookup SHALL return the pre-update contents (no bypass), and the update SHALL take effect in the next cycle.
REQ-016 br_count SHALL increment by 1 on each upd_en.
REQ-017 mispred_count SHALL increment by 1 on each upd_en where upd_pred_taken != upd_taken, or where upd_taken = 1 and upd_pred_taken = 1 but the stored target != upd_target[31:2].
REQ-018 Both statistics counters SHALL saturate at 32'hFFFFFFFF.
REQ-019 When stat_clr = 1, both counters SHALL be cleared to 0, with priority over any increment in the same cycle. Table state SHALL be unaffected.
REQ-020 An update to an index whose entry is invalid SHALL follow REQ-012 and REQ-013.

Reset
REQ-021 While RST = 1, the block SHALL asynchronously clear all valid bits, all cnt fields, ghr, br_count and mispred_count to 0. Tag and target fields need no reset.
REQ-022 During and after reset, the outputs SHALL be: pred_hit = 0, pred_taken = 0, pred_target = lookup_pc + 4, br_count = 0, mispred_count = 0.
REQ-023 RST asserted mid-update SHALL win: the entry is left invalid.

Verification
REQ-024 The bench SHALL cover the following directed scenarios (ENTRIES = 16, CNT_W = 2, MODE = 0 unless stated):
- Reset, then lookup_pc = 0x40 -> pred_hit = 0, pred_taken = 0, pred_target = 0x44, pred_idx = 0.
- Update upd_pc = 0x40, upd_idx = 0, upd_taken = 1, upd_target = 0x100; then lookup 0x40 -> pred_hit = 1, pred_taken = 1, pred_target = 0x100, cnt = 2'b10.
- Four not-taken updates to 0x40 -> cnt = 0 (saturated), pred_taken = 0; one taken update -> cnt = 1, still not taken.
- Aliasing: lookup 0x440 after 0x40 is allocated -> pred_idx = 0, pred_hit = 0; a taken update of 0x440 replaces the entry, after which lookup 0x40 -> pred_hit = 0.
- MODE = 1, HIST_W = 4: updates taken, taken, not-taken -> ghr = 4'b0110; lookup 0x40 -> pred_idx = 6.
- Statistics: 3 updates with one mispredict -> br_count = 3, mispred_count = 1; stat_clr coincident with an update -> both counters 0. Same-cycle lookup and update on index 0 -> lookup returns the old cnt.
